// File: rtl/dft_capture_buffer.sv
// rtl/dft_capture_buffer.sv - per-chain scan capture buffers with status word and registered read port
module dft_capture_buffer #(
    parameter int          P_SC_NBR = 16,
    parameter int          P_DEPTH  = 64,
    parameter int          P_DATA_W = 32,
    parameter logic [31:0] P_BASE   = 32'h00000020
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 capture_start,
    input  logic [$clog2(P_DEPTH):0]             capture_len,
    input  logic                                 capture_en,
    input  logic [P_SC_NBR*P_DATA_W-1:0]         dft_output_data,
    input  logic                                 axi_rd_en,
    input  logic [31:0]                          axi_rd_addr,
    output logic [P_DATA_W-1:0]                  axi_rd_msg,
    output logic                                 axi_rd_valid,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 overflow,
    output logic [$clog2(P_DEPTH):0]             wr_ptr
);

    localparam int LW    = $clog2(P_DEPTH);
    localparam int W     = LW + 1;
    localparam int TOTAL = P_SC_NBR * P_DEPTH;
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [W-1:0]        len_q, len_d;
    logic                ovf_q, ovf_d;
    logic                wr_en;
    logic [W-1:0]        wr_ptr_inc;
    logic [P_DATA_W-1:0] mem [TOTAL];
    logic [P_DATA_W-1:0] rd_data;
    logic [P_DATA_W-1:0] status_word;
    logic [31:0]         rd_off;

    assign wr_ptr_inc = wr_ptr_q + W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
        end
    end

    // A start pulse wins over everything else, including a same-cycle capture beat.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        wr_en    = 1'b0;
        if (capture_start) begin
            state_d  = S_CAPTURE;
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
            len_d    = (capture_len > W'(P_DEPTH)) ? W'(P_DEPTH) : capture_len;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_CAPTURE: begin
                    if (len_q == '0) begin
                        state_d = S_DONE;
                    end else if (capture_en) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_inc;
                        if (wr_ptr_inc == len_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (capture_en) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Chain i occupies the contiguous block [i*P_DEPTH, (i+1)*P_DEPTH).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < P_SC_NBR; i++) begin
                mem[AW'(i * P_DEPTH) + AW'(wr_ptr_q[LW-1:0])] <= dft_output_data[P_DATA_W*i +: P_DATA_W];
            end
        end
    end

    assign rd_off = axi_rd_addr - P_BASE;

    always_comb begin
        status_word        = '0;
        status_word[W-1:0] = wr_ptr_q;
        status_word[W]     = (state_q == S_CAPTURE);
        status_word[W+1]   = (state_q == S_DONE);
        status_word[W+2]   = ovf_q;
        rd_data            = '0;
        if (axi_rd_addr >= P_BASE) begin
            if (rd_off < 32'(TOTAL)) begin
                rd_data = mem[rd_off[AW-1:0]];
            end else if (rd_off == 32'(TOTAL)) begin
                rd_data = status_word;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            axi_rd_msg   <= '0;
            axi_rd_valid <= 1'b0;
        end else begin
            axi_rd_valid <= axi_rd_en;
            axi_rd_msg   <= axi_rd_en ? rd_data : '0;
        end
    end

    assign busy     = (state_q == S_CAPTURE);
    assign done     = (state_q == S_DONE);
    assign overflow = ovf_q;
    assign wr_ptr   = wr_ptr_q;

endmodule

// File: tb/tb_dft_capture_buffer.sv
// tb/tb_dft_capture_buffer.sv - directed and random checks of dft_capture_buffer against a behavioural model
module tb_dft_capture_buffer;

    localparam int          NC   = 16;
    localparam int          D    = 64;
    localparam int          DW   = 32;
    localparam int          W    = 7;
    localparam logic [31:0] BASE = 32'h00000020;

    logic              clk = 1'b0;
    logic              reset;
    logic              capture_start;
    logic [W-1:0]      capture_len;
    logic              capture_en;
    logic [NC*DW-1:0]  dft_output_data;
    logic              axi_rd_en;
    logic [31:0]       axi_rd_addr;
    logic [DW-1:0]     axi_rd_msg;
    logic              axi_rd_valid;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [W-1:0]      wr_ptr;

    dft_capture_buffer #(
        .P_SC_NBR (NC),
        .P_DEPTH  (D),
        .P_DATA_W (DW),
        .P_BASE   (BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .capture_start   (capture_start),
        .capture_len     (capture_len),
        .capture_en      (capture_en),
        .dft_output_data (dft_output_data),
        .axi_rd_en       (axi_rd_en),
        .axi_rd_addr     (axi_rd_addr),
        .axi_rd_msg      (axi_rd_msg),
        .axi_rd_valid    (axi_rd_valid),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .wr_ptr          (wr_ptr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mbuf   [NC][D];
    bit          mknown [NC][D];
    bit          m_cap, m_done, m_ovf;
    int          m_cnt, m_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_read(input logic [31:0] a, output logic [31:0] d, output bit known);
        logic [31:0] off;
        int c, w;
        d     = 32'h0;
        known = 1'b1;
        if (a < BASE) return;
        off = a - BASE;
        if (off < 32'(NC * D)) begin
            c     = int'(off) / D;
            w     = int'(off) % D;
            d     = mbuf[c][w];
            known = mknown[c][w];
        end else if (off == 32'(NC * D)) begin
            d = 32'(m_cnt) + 32'(m_cap) * 128 + 32'(m_done) * 256 + 32'(m_ovf) * 512;
        end
    endfunction

    task automatic model_reset();
        m_cap  = 1'b0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
        m_len  = 0;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(m_cap));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_wr_ptr"}, 32'(wr_ptr), 32'(m_cnt));
    endtask

    // One clock: predict read result from pre-edge model state, then advance the model.
    task automatic cycle();
        logic [31:0] em;
        bit          known;
        bit          ev;
        ev    = axi_rd_en;
        em    = 32'h0;
        known = 1'b1;
        if (axi_rd_en) model_read(axi_rd_addr, em, known);
        @(posedge clk);
        if (capture_start) begin
            m_cap  = 1'b1;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_cnt  = 0;
            m_len  = (int'(capture_len) > D) ? D : int'(capture_len);
        end else if (m_cap) begin
            if (m_len == 0) begin
                m_cap  = 1'b0;
                m_done = 1'b1;
            end else if (capture_en) begin
                for (int c = 0; c < NC; c++) begin
                    mbuf[c][m_cnt]   = dft_output_data[c*DW +: DW];
                    mknown[c][m_cnt] = 1'b1;
                end
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_cap  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (m_done && capture_en) begin
            m_ovf = 1'b1;
        end
        #1;
        chk("rd_valid", 32'(axi_rd_valid), 32'(ev));
        if (known) chk("rd_msg", axi_rd_msg, em);
        check_flags("cyc");
        capture_start = 1'b0;
        capture_en    = 1'b0;
        axi_rd_en     = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        capture_start = 1'b0;
        capture_en    = 1'b0;
        axi_rd_en     = 1'b0;
        model_reset();
        #1;
        check_flags("rst");
        chk("rst_valid", 32'(axi_rd_valid), 32'h0);
        chk("rst_msg", axi_rd_msg, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_pattern(input int beat);
        for (int c = 0; c < NC; c++) dft_output_data[c*DW +: DW] = 32'(256 * c + beat);
    endtask

    task automatic set_random();
        for (int c = 0; c < NC; c++) dft_output_data[c*DW +: DW] = $urandom;
    endtask

    task automatic rd(input logic [31:0] a);
        axi_rd_en   = 1'b1;
        axi_rd_addr = a;
    endtask

    initial begin
        int          pat [6] = '{1, 0, 1, 1, 0, 1};
        int          beat;
        logic [31:0] saved;
        logic [31:0] newv;

        reset           = 1'b1;
        capture_start   = 1'b0;
        capture_len     = '0;
        capture_en      = 1'b0;
        dft_output_data = '0;
        axi_rd_en       = 1'b0;
        axi_rd_addr     = '0;
        model_reset();
        for (int c = 0; c < NC; c++)
            for (int w = 0; w < D; w++) mknown[c][w] = 1'b0;

        do_reset();
        rd(BASE);
        cycle();
        rd(BASE + NC * D);
        cycle();
        chk("status_after_reset", axi_rd_msg, 32'h0);

        // len 4 with gapped enables
        capture_len   = 7'd4;
        capture_start = 1'b1;
        cycle();
        beat = 0;
        for (int k = 0; k < 6; k++) begin
            if (pat[k] != 0) begin
                capture_en = 1'b1;
                set_pattern(beat);
                beat++;
            end
            cycle();
        end
        chk("len4_done", 32'(done), 32'h1);
        chk("len4_wr_ptr", 32'(wr_ptr), 32'd4);
        rd(BASE + 64 * 3 + 2);
        cycle();
        chk("word_3_2", axi_rd_msg, 32'h302);

        // zero-length capture
        capture_len   = 7'd0;
        capture_start = 1'b1;
        cycle();
        chk("len0_busy", 32'(busy), 32'h1);
        capture_en = 1'b1;
        set_random();
        cycle();
        chk("len0_done", 32'(done), 32'h1);
        chk("len0_wr_ptr", 32'(wr_ptr), 32'h0);
        rd(BASE + 64 * 3 + 2);
        cycle();
        chk("len0_unchanged", axi_rd_msg, 32'h302);

        // overlength request clamps to depth, then overflow in DONE
        capture_len   = 7'd100;
        capture_start = 1'b1;
        cycle();
        beat = 0;
        for (int k = 0; k < 300 && beat < D; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                capture_en = 1'b1;
                set_random();
                beat++;
            end
            cycle();
        end
        chk("clamp_wr_ptr", 32'(wr_ptr), 32'd64);
        chk("clamp_done", 32'(done), 32'h1);
        capture_en = 1'b1;
        cycle();
        chk("overflow_set", 32'(overflow), 32'h1);
        rd(BASE + NC * D);
        cycle();
        chk("status_ovf", axi_rd_msg, 32'h340);
        chk("status_bit8", 32'(axi_rd_msg[8]), 32'h1);

        // restart mid-capture
        capture_len   = 7'd8;
        capture_start = 1'b1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            capture_en = 1'b1;
            set_random();
            cycle();
        end
        saved         = mbuf[0][2];
        capture_len   = 7'd2;
        capture_start = 1'b1;
        capture_en    = 1'b1;
        set_random();
        cycle();
        chk("restart_wr_ptr", 32'(wr_ptr), 32'h0);
        for (int k = 0; k < 2; k++) begin
            capture_en = 1'b1;
            set_random();
            cycle();
        end
        chk("restart_done", 32'(done), 32'h1);
        for (int k = 0; k < 3; k++) begin
            rd(BASE + k);
            cycle();
        end
        chk("restart_old_word2", axi_rd_msg, saved);

        // unmapped addresses
        rd(32'h1F);
        cycle();
        chk("below_base", axi_rd_msg, 32'h0);
        rd(BASE + NC * D + 1);
        cycle();
        chk("past_status", axi_rd_msg, 32'h0);
        chk("past_status_valid", 32'(axi_rd_valid), 32'h1);

        // read/write collision returns old data
        capture_len   = 7'd4;
        capture_start = 1'b1;
        cycle();
        saved      = mbuf[5][0];
        capture_en = 1'b1;
        set_random();
        newv = dft_output_data[5*DW +: DW];
        rd(BASE + 5 * D);
        cycle();
        chk("collision_old", axi_rd_msg, saved);
        rd(BASE + 5 * D);
        cycle();
        chk("collision_new", axi_rd_msg, newv);

        // random traffic, including asynchronous resets mid-capture
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 29) == 0) begin
                    capture_start = 1'b1;
                    capture_len   = 7'($urandom_range(0, 127));
                end
                capture_en = ($urandom_range(0, 9) < 6);
                set_random();
                if ($urandom_range(0, 9) < 7) begin
                    case ($urandom_range(0, 9))
                        0:       rd(BASE + NC * D);
                        1:       rd(32'($urandom_range(0, 32'h500)));
                        default: rd(BASE + 32'($urandom_range(0, NC * D - 1)));
                    endcase
                end
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
